// File: rtl/snn_spike_classifier_pkg.sv
// Shared definitions for the spike classifier: FSM encoding, default sizes
// and the index-width helper used by the interface and the top.
package snn_spike_classifier_pkg;

    localparam int CLASSES_DEF     = 8;
    localparam int COUNT_BITS_DEF  = 8;
    localparam int WINDOW_BITS_DEF = 8;

    localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
    localparam logic [1:0] ST_ACCUM_ENC = 2'd1;
    localparam logic [1:0] ST_SCAN_ENC  = 2'd2;
    localparam logic [1:0] ST_DONE_ENC  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = ST_IDLE_ENC,
        ST_ACCUM = ST_ACCUM_ENC,
        ST_SCAN  = ST_SCAN_ENC,
        ST_DONE  = ST_DONE_ENC
    } state_t;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/snn_spike_classifier_if.sv
// Host/network side bundle of the classifier. The network drives enable/spikes,
// the host drives start/window_len; there is no backpressure, start is a pulse.
interface snn_spike_classifier_if
    import snn_spike_classifier_pkg::*;
#(
    parameter int CLASSES     = CLASSES_DEF,
    parameter int COUNT_BITS  = COUNT_BITS_DEF,
    parameter int WINDOW_BITS = WINDOW_BITS_DEF
) ();

    localparam int IDX_W = idx_width(CLASSES);

    logic                   enable;
    logic [CLASSES-1:0]     spikes;
    logic                   start;
    logic [WINDOW_BITS-1:0] window_len;
    logic                   busy;
    logic                   done;
    logic                   valid;
    logic [IDX_W-1:0]       winner;
    logic [COUNT_BITS-1:0]  winner_count;
    logic                   tie;
    state_t                 fsm_state;

    modport master (
        output enable, spikes, start, window_len,
        input  busy, done, valid, winner, winner_count, tie, fsm_state
    );

    modport slave (
        input  enable, spikes, start, window_len,
        output busy, done, valid, winner, winner_count, tie, fsm_state
    );

endinterface

// File: rtl/snn_sat_counter.sv
// Per-class spike counter: clears on request, increments by one, sticks at
// all-ones instead of wrapping.
module snn_sat_counter #(
    parameter int COUNT_BITS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  inc,
    output logic [COUNT_BITS-1:0] count
);

    localparam logic [COUNT_BITS-1:0] COUNT_MAX = '1;

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (inc && (count != COUNT_MAX)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/snn_spike_classifier.sv
// Counts output-layer spikes over a window of execute timesteps, then runs a
// one-class-per-cycle argmax scan and holds winner/count/tie for the host.
module snn_spike_classifier
    import snn_spike_classifier_pkg::*;
#(
    parameter int CLASSES     = CLASSES_DEF,
    parameter int COUNT_BITS  = COUNT_BITS_DEF,
    parameter int WINDOW_BITS = WINDOW_BITS_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    snn_spike_classifier_if.slave  bus
);

    localparam int               IDX_W    = idx_width(CLASSES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CLASSES - 1);

    state_t                 state_q;
    state_t                 state_d;
    logic [WINDOW_BITS-1:0] remaining_q;
    logic [IDX_W-1:0]       scan_idx_q;
    logic [IDX_W-1:0]       best_idx_q;
    logic [COUNT_BITS-1:0]  best_cnt_q;
    logic                   best_tie_q;
    logic [IDX_W-1:0]       winner_q;
    logic [COUNT_BITS-1:0]  winner_count_q;
    logic                   tie_q;
    logic                   valid_q;

    logic [COUNT_BITS-1:0]  cnt [CLASSES];
    logic [COUNT_BITS-1:0]  cur_cnt;
    logic                   start_ok;
    logic                   sample;
    logic                   last_sample;
    logic                   scan_last;
    logic [IDX_W-1:0]       step_idx;
    logic [COUNT_BITS-1:0]  step_cnt;
    logic                   step_tie;

    assign start_ok    = (state_q == ST_IDLE) && bus.start;
    assign sample      = (state_q == ST_ACCUM) && bus.enable;
    assign last_sample = sample && (remaining_q == WINDOW_BITS'(1));
    assign scan_last   = (state_q == ST_SCAN) && (scan_idx_q == LAST_IDX);
    assign cur_cnt     = cnt[scan_idx_q];

    for (genvar i = 0; i < CLASSES; i++) begin : g_cnt
        snn_sat_counter #(
            .COUNT_BITS (COUNT_BITS)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .clear (start_ok),
            .inc   (sample && bus.spikes[i]),
            .count (cnt[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = (bus.window_len == '0) ? ST_SCAN : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (last_sample) begin
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (scan_idx_q == LAST_IDX) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // One comparator step; slot 0 seeds the running best, strict '>' keeps
    // the lowest index on equal counts.
    always_comb begin
        step_idx = best_idx_q;
        step_cnt = best_cnt_q;
        step_tie = best_tie_q;
        if (scan_idx_q == '0) begin
            step_idx = '0;
            step_cnt = cur_cnt;
            step_tie = 1'b0;
        end else if (cur_cnt > best_cnt_q) begin
            step_idx = scan_idx_q;
            step_cnt = cur_cnt;
            step_tie = 1'b0;
        end else if (cur_cnt == best_cnt_q) begin
            step_tie = 1'b1;
        end
    end

    // The published result is loaded on the last scan step so it is already
    // visible during the done cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            remaining_q    <= '0;
            scan_idx_q     <= '0;
            best_idx_q     <= '0;
            best_cnt_q     <= '0;
            best_tie_q     <= 1'b0;
            winner_q       <= '0;
            winner_count_q <= '0;
            tie_q          <= 1'b0;
            valid_q        <= 1'b0;
        end else begin
            if (start_ok) begin
                remaining_q <= bus.window_len;
                scan_idx_q  <= '0;
                valid_q     <= 1'b0;
            end
            if (sample) begin
                remaining_q <= remaining_q - 1'b1;
            end
            if (state_q == ST_SCAN) begin
                scan_idx_q <= scan_idx_q + 1'b1;
                best_idx_q <= step_idx;
                best_cnt_q <= step_cnt;
                best_tie_q <= step_tie;
            end
            if (scan_last) begin
                winner_q       <= step_idx;
                winner_count_q <= step_cnt;
                tie_q          <= step_tie;
                valid_q        <= 1'b1;
            end
        end
    end

    assign bus.busy         = (state_q == ST_ACCUM) || (state_q == ST_SCAN);
    assign bus.done         = (state_q == ST_DONE);
    assign bus.valid        = valid_q;
    assign bus.winner       = winner_q;
    assign bus.winner_count = winner_count_q;
    assign bus.tie          = tie_q;
    assign bus.fsm_state    = state_q;

endmodule

// File: tb/tb_snn_spike_classifier.sv
// Bench for the spike classifier: an 8-bit-counter and a 4-bit-counter instance
// share one stimulus stream and are checked against a per-window model.
module tb_snn_spike_classifier;
    import snn_spike_classifier_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic       drv_enable;
    logic       drv_start;
    logic [7:0] drv_spikes;
    logic [7:0] drv_window_len;

    snn_spike_classifier_if #(.CLASSES(8), .COUNT_BITS(8), .WINDOW_BITS(8)) bus8 ();
    snn_spike_classifier_if #(.CLASSES(8), .COUNT_BITS(4), .WINDOW_BITS(8)) bus4 ();

    assign bus8.enable     = drv_enable;
    assign bus8.spikes     = drv_spikes;
    assign bus8.start      = drv_start;
    assign bus8.window_len = drv_window_len;
    assign bus4.enable     = drv_enable;
    assign bus4.spikes     = drv_spikes;
    assign bus4.start      = drv_start;
    assign bus4.window_len = drv_window_len;

    snn_spike_classifier #(.CLASSES(8), .COUNT_BITS(8), .WINDOW_BITS(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8)
    );

    snn_spike_classifier #(.CLASSES(8), .COUNT_BITS(4), .WINDOW_BITS(8)) dut4 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus4)
    );

    // ---------------- scoreboard ----------------
    int n_cmp = 0;
    int n_err = 0;
    int ncyc  = 0;
    int raw [8];
    // {win8[3], cnt8[8], tie8, win4[3], cnt4[4], tie4}
    logic [19:0] exp_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, got, exp, ncyc);
        end
    endtask

    // Class decision straight from the rules: saturate the raw tallies, the
    // first maximum wins, a tie is any second class holding that maximum.
    function automatic logic [19:0] model_result();
        int c8 [8];
        int c4 [8];
        int w8 = 0;
        int w4 = 0;
        int n8 = 0;
        int n4 = 0;
        for (int i = 0; i < 8; i++) begin
            c8[i] = (raw[i] > 255) ? 255 : raw[i];
            c4[i] = (raw[i] > 15) ? 15 : raw[i];
        end
        for (int i = 1; i < 8; i++) begin
            if (c8[i] > c8[w8]) w8 = i;
            if (c4[i] > c4[w4]) w4 = i;
        end
        for (int i = 0; i < 8; i++) begin
            if (c8[i] == c8[w8]) n8++;
            if (c4[i] == c4[w4]) n4++;
        end
        return {3'(w8), 8'(c8[w8]), (n8 > 1), 3'(w4), 4'(c4[w4]), (n4 > 1)};
    endfunction

    task automatic check_result(input string tag);
        logic [19:0] e;
        e = exp_q.pop_front();
        check_eq({tag, "_win8"}, 32'(bus8.winner), 32'(e[19:17]));
        check_eq({tag, "_cnt8"}, 32'(bus8.winner_count), 32'(e[16:9]));
        check_eq({tag, "_tie8"}, 32'(bus8.tie), 32'(e[8]));
        check_eq({tag, "_win4"}, 32'(bus4.winner), 32'(e[7:5]));
        check_eq({tag, "_cnt4"}, 32'(bus4.winner_count), 32'(e[4:1]));
        check_eq({tag, "_tie4"}, 32'(bus4.tie), 32'(e[0]));
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
        ncyc++;
    endtask

    // en_mode: 0 always on, 1 alternating 1,0,1,..., 2 random ~70%.
    // spk_fixed < 0 selects random spikes.
    task automatic run_window(input string tag, input int wlen, input int en_mode,
                              input int spk_fixed, input bit restart_mid);
        int         n = 0;
        int         k = 0;
        int         t_exp;
        logic       en;
        logic [7:0] sp;
        for (int i = 0; i < 8; i++) raw[i] = 0;
        drv_start      = 1'b1;
        drv_window_len = 8'(wlen);
        drv_enable     = 1'($urandom);
        drv_spikes     = 8'($urandom);
        t_exp          = ncyc + 9;
        step();
        drv_start = 1'b0;
        check_eq({tag, "_busy_start"}, 32'(bus8.busy), 32'd1);
        check_eq({tag, "_valid_start"}, 32'(bus8.valid), 32'd0);
        while (n < wlen) begin
            en = (en_mode == 0) ? 1'b1 :
                 (en_mode == 1) ? ((k % 2) == 0) : ($urandom_range(0, 9) < 7);
            sp = (spk_fixed >= 0) ? 8'(spk_fixed) : 8'($urandom);
            drv_enable = en;
            drv_spikes = sp;
            drv_start  = restart_mid && (k == 1);
            if (en) begin
                n++;
                for (int i = 0; i < 8; i++) raw[i] += int'(sp[i]);
                if (n == wlen) t_exp = ncyc + 9;
            end
            k++;
            step();
        end
        drv_start = 1'b0;
        exp_q.push_back(model_result());
        while (bus8.done !== 1'b1 && ncyc < t_exp + 4) begin
            if (ncyc == t_exp - 1) begin
                check_eq({tag, "_busy_scan"}, 32'(bus8.busy), 32'd1);
                check_eq({tag, "_valid_scan"}, 32'(bus4.valid), 32'd0);
            end
            drv_enable = 1'($urandom);
            drv_spikes = 8'($urandom);
            step();
        end
        check_eq({tag, "_done_cyc"}, 32'(ncyc), 32'(t_exp));
        check_eq({tag, "_done4"}, 32'(bus4.done), 32'd1);
        check_eq({tag, "_valid8"}, 32'(bus8.valid), 32'd1);
        check_eq({tag, "_valid4"}, 32'(bus4.valid), 32'd1);
        check_result(tag);
        drv_enable = 1'b0;
        step();
        check_eq({tag, "_done_pulse"}, 32'(bus8.done), 32'd0);
        check_eq({tag, "_busy_after"}, 32'(bus8.busy), 32'd0);
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int seen_done;
        reset          = 1'b1;
        drv_enable     = 1'b0;
        drv_start      = 1'b0;
        drv_spikes     = 8'h00;
        drv_window_len = 8'h00;
        repeat (3) step();
        reset = 1'b0;
        step();
        check_eq("rst_state", 32'(bus8.fsm_state), 32'(ST_IDLE));
        check_eq("rst_busy", 32'(bus8.busy), 32'd0);
        check_eq("rst_done", 32'(bus8.done), 32'd0);
        check_eq("rst_valid", 32'(bus8.valid), 32'd0);
        check_eq("rst_winner", 32'(bus8.winner), 32'd0);
        check_eq("rst_count", 32'(bus8.winner_count), 32'd0);
        check_eq("rst_tie", 32'(bus8.tie), 32'd0);
        check_eq("rst_valid4", 32'(bus4.valid), 32'd0);

        run_window("w4", 4, 0, 8'h04, 1'b0);
        check_eq("w4_winner", 32'(bus8.winner), 32'd2);
        check_eq("w4_count", 32'(bus8.winner_count), 32'd4);
        check_eq("w4_tie", 32'(bus8.tie), 32'd0);

        // Reset in the middle of the scan drops the result entirely.
        drv_start      = 1'b1;
        drv_window_len = 8'd1;
        step();
        drv_start  = 1'b0;
        drv_enable = 1'b1;
        drv_spikes = 8'h10;
        repeat (3) step();
        check_eq("rs_in_scan", 32'(bus8.fsm_state), 32'(ST_SCAN));
        reset = 1'b1;
        step();
        reset = 1'b0;
        drv_enable = 1'b0;
        check_eq("rs_busy", 32'(bus8.busy), 32'd0);
        check_eq("rs_valid", 32'(bus8.valid), 32'd0);
        check_eq("rs_winner", 32'(bus8.winner), 32'd0);
        check_eq("rs_count", 32'(bus8.winner_count), 32'd0);
        check_eq("rs_tie", 32'(bus4.tie), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus8.done === 1'b1 || bus4.done === 1'b1) seen_done++;
            step();
        end
        check_eq("rs_no_done", 32'(seen_done), 32'd0);

        run_window("alt", 3, 1, 8'h81, 1'b0);
        check_eq("alt_winner", 32'(bus8.winner), 32'd0);
        check_eq("alt_count", 32'(bus8.winner_count), 32'd3);
        check_eq("alt_tie", 32'(bus8.tie), 32'd1);

        run_window("sat", 255, 0, 8'h80, 1'b0);
        check_eq("sat_win4", 32'(bus4.winner), 32'd7);
        check_eq("sat_cnt4", 32'(bus4.winner_count), 32'd15);
        check_eq("sat_tie4", 32'(bus4.tie), 32'd0);
        check_eq("sat_cnt8", 32'(bus8.winner_count), 32'd255);

        run_window("zero", 0, 0, -1, 1'b0);
        check_eq("zero_winner", 32'(bus8.winner), 32'd0);
        check_eq("zero_count", 32'(bus8.winner_count), 32'd0);
        check_eq("zero_tie", 32'(bus8.tie), 32'd1);

        run_window("restart", 6, 2, -1, 1'b1);

        for (int w = 0; w < 24; w++) begin
            run_window("rnd", int'($urandom_range(0, 40)), 2, -1, ($urandom_range(0, 3) == 0));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
